// File: rtl/hysteresis_frame_ctrl_if.sv
// Port bundle between the hysteresis frame controller, its writer/reader
// stages and the single-port image BRAM.
interface hysteresis_frame_ctrl_if #(
  parameter int AW = 19
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          wr_ready;
  logic          frame_done;
  logic          hough_start;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          hough_done;
  logic          bram_en;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [7:0]    bram_din;
  logic [7:0]    bram_dout;
  logic [15:0]   frame_count;
  logic          wr_overrun;
  logic          rd_overrun;

  // Controller side.
  modport slave (
    input  wr_en, wr_addr, wr_data, frame_done,
    input  rd_en, rd_addr, hough_done, bram_dout,
    output wr_ready, hough_start, rd_data, rd_valid,
    output bram_en, bram_we, bram_addr, bram_din,
    output frame_count, wr_overrun, rd_overrun
  );

  // Requester / BRAM side.
  modport master (
    output wr_en, wr_addr, wr_data, frame_done,
    output rd_en, rd_addr, hough_done, bram_dout,
    input  wr_ready, hough_start, rd_data, rd_valid,
    input  bram_en, bram_we, bram_addr, bram_din,
    input  frame_count, wr_overrun, rd_overrun
  );
endinterface

// File: rtl/hysteresis_frame_ctrl.sv
// Frame-level owner of the hysteresis image BRAM: zero-clear, hand the port to
// the writer for one frame, then to the Hough reader, and flag misuse.
module hysteresis_frame_ctrl #(
  parameter int WIDTH      = 720,
  parameter int HEIGHT     = 540,
  parameter int IMAGE_SIZE = WIDTH * HEIGHT,
  parameter int AW         = $clog2(IMAGE_SIZE)
) (
  input  logic                    clock,
  input  logic                    reset,
  hysteresis_frame_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    FILL  = 2'd1,
    READ  = 2'd2
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(IMAGE_SIZE - 1);

  state_t        state, state_next;
  logic [AW-1:0] clr_addr, clr_addr_next;
  logic          rd_accept;
  logic          rd_valid_q;
  logic [7:0]    rd_data_q;

  // NOTE: every signal gets a default before the case so no path leaves a
  // value unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_next    = CLEAR;
    clr_addr_next = '0;
    bus.bram_en   = 1'b0;
    bus.bram_we   = 1'b0;
    bus.bram_addr = '0;
    bus.bram_din  = '0;
    bus.wr_ready  = 1'b0;
    rd_accept     = 1'b0;

    case (state)
      CLEAR: begin
        bus.bram_en   = 1'b1;
        bus.bram_we   = 1'b1;
        bus.bram_addr = clr_addr;
        if (clr_addr == LAST_ADDR) begin
          state_next = FILL;
        end else begin
          state_next    = CLEAR;
          clr_addr_next = clr_addr + AW'(1);
        end
      end
      FILL: begin
        bus.wr_ready  = 1'b1;
        bus.bram_en   = bus.wr_en;
        bus.bram_we   = bus.wr_en;
        bus.bram_addr = bus.wr_addr;
        bus.bram_din  = bus.wr_data;
        state_next    = bus.frame_done ? READ : FILL;
      end
      READ: begin
        bus.bram_en   = bus.rd_en;
        bus.bram_addr = bus.rd_addr;
        rd_accept     = bus.rd_en;
        state_next    = bus.hough_done ? CLEAR : READ;
      end
      // Unused encoding falls back to a fresh clear from address 0.
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= CLEAR;
      clr_addr        <= '0;
      bus.hough_start <= 1'b0;
      rd_valid_q      <= 1'b0;
      rd_data_q       <= '0;
      bus.frame_count <= '0;
      bus.wr_overrun  <= 1'b0;
      bus.rd_overrun  <= 1'b0;
    end else begin
      state           <= state_next;
      clr_addr        <= clr_addr_next;
      bus.hough_start <= (state == FILL) && bus.frame_done;
      rd_valid_q      <= rd_accept;
      if (rd_valid_q) rd_data_q <= bus.bram_dout;
      if ((state == READ) && bus.hough_done) bus.frame_count <= bus.frame_count + 16'd1;
      if (bus.wr_en && (state != FILL)) bus.wr_overrun <= 1'b1;
      if (bus.rd_en && (state != READ)) bus.rd_overrun <= 1'b1;
    end
  end

  // BRAM output is already registered, so return it straight through on the
  // valid cycle and hold the captured copy afterwards.
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_valid_q ? bus.bram_dout : rd_data_q;

endmodule

// File: doc/hysteresis_frame_ctrl.md
# hysteresis_frame_ctrl

Frame-level controller for the single-port hysteresis image BRAM between the `hysteresis` stage (writer) and the `hough` stage (reader). It zero-clears the full-image BRAM, grants the port to the writer for one frame, then hands it to the reader. It issues the `hough_start` pulse, returns the port to clear for the next frame on `hough_done`, and flags protocol violations.

## Interface
Parameters:
- `WIDTH`, 720: full image width in pixels.
- `HEIGHT`, 540: full image height in pixels.
- `IMAGE_SIZE`, WIDTH*HEIGHT: BRAM depth in pixels.
- `AW`, $clog2(IMAGE_SIZE): address width.

Ports:
- `clock`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `wr_en`  in  1  writer write strobe.
- `wr_addr`  in  AW  writer address.
- `wr_data`  in  8  writer data.
- `wr_ready`  out  1  writer owns the port (FILL).
- `frame_done`  in  1  one-cycle pulse from the writer: frame fully written.
- `hough_start`  out  1  one-cycle pulse: BRAM holds a complete frame.
- `rd_en`  in  1  reader read strobe.
- `rd_addr`  in  AW  reader address.
- `rd_data`  out  8  read data.
- `rd_valid`  out  1  `rd_data` valid.
- `hough_done`  in  1  one-cycle pulse from the reader: frame consumed.
- `bram_en`, `bram_we`  out  1  BRAM port enable and write enable.
- `bram_addr`  out  AW  BRAM address.
- `bram_din`  out  8  BRAM write data.
- `bram_dout`  in  8  BRAM read data; registered, 1-cycle latency.
- `frame_count`  out  16  completed frames; wraps at 2^16.
- `wr_overrun`  out  1  sticky: `wr_en` seen outside FILL.
- `rd_overrun`  out  1  sticky: `rd_en` seen outside READ.

## Operation
States: CLEAR, FILL, READ. There are no others; an illegal encoding goes to CLEAR with `clr_addr`=0.

- **Reset.** Enter CLEAR with `clr_addr`=0. All registered outputs are 0: `hough_start`, `rd_valid`, `rd_data`, `frame_count`, `wr_overrun`, `rd_overrun`. A reset in any state aborts the frame and restarts CLEAR from address 0.
- **CLEAR.**
  - Drive `bram_en`=1, `bram_we`=1, `bram_addr`=`clr_addr`, `bram_din`=0. Increment `clr_addr` every cycle.
  - When `clr_addr`==IMAGE_SIZE-1, write that address, then go to FILL. `clr_addr` returns to 0.
  - `wr_ready`=0.
  - Clearing is required because the writer covers only the reduced window; pixels outside it must read 0.
- **FILL.**
  - `wr_ready`=1.
  - Port is a combinational pass-through: `bram_en`=`bram_we`=`wr_en`, `bram_addr`=`wr_addr`, `bram_din`=`wr_data`.
  - On `frame_done`, go to READ. A `wr_en` in the same cycle is still written.
  - Next cycle, `hough_start`=1 for exactly one cycle.
- **READ.**
  - `bram_en`=`rd_en`, `bram_we`=0, `bram_addr`=`rd_addr`.
  - On `hough_done`, increment `frame_count` and go to CLEAR. A `rd_en` in the same cycle is still issued and returns data.
- **Read return.** `rd_valid` is `rd_en`-accepted delayed by one cycle. `rd_data` = `bram_dout` in the cycle `rd_valid`=1. `rd_data` holds its value otherwise.
- **Violations.**
  - A `wr_en` outside FILL is dropped and sets `wr_overrun`.
  - A `rd_en` outside READ is dropped, produces no `rd_valid`, and sets `rd_overrun`.
  - Overrun flags clear only on `reset`.
- **Ignored pulses.** `frame_done` outside FILL and `hough_done` outside READ are ignored, with no flag.
- **Arithmetic.** `clr_addr` is AW bits and compares exactly to IMAGE_SIZE-1; no wrap past the end. `frame_count` is 16-bit modulo.

## Timing
- The BRAM port mux is combinational from the state register and the requester inputs. There is zero added latency on the write path.
- Read latency is 1 cycle from `rd_en` to `rd_valid`. Reads are fully pipelined: back-to-back `rd_en` gives back-to-back `rd_valid`.
- CLEAR takes exactly IMAGE_SIZE cycles. `wr_ready` rises on cycle IMAGE_SIZE after reset deassertion, or after the `hough_done` edge.
- `frame_done` at cycle t:
  - state=READ at t+1;
  - `hough_start`=1 at t+1 only.
- `hough_done` at cycle t:
  - state=CLEAR at t+1;
  - `frame_count` updates at t+1;
  - `wr_ready`=0 at t+1.
- A `rd_en` at t, including the `hough_done` cycle, yields `rd_valid` at t+1 even though the state is then CLEAR.

## Test plan
All scenarios use WIDTH=4, HEIGHT=3, IMAGE_SIZE=12.
- **Reset and clear.** Deassert `reset`, then stall 12 cycles. Required: `bram_we`=1 at addresses 0..11 with `bram_din`=0, `wr_ready`=0 throughout, `wr_ready`=1 on cycle 12, all status outputs 0.
- **Write frame.** In FILL, write address 5=0x40 and address 6=0x0D. Pulse `frame_done` together with the write of address 6. Required: both writes reach the BRAM, `hough_start` is a single pulse the next cycle, state=READ.
- **Readback.** In READ, issue `rd_en` at addresses 5, 6, 0 on consecutive cycles. Required: `rd_valid` on the 3 following cycles with data 0x40, 0x0D, 0x00.
- **Frame handoff.** Pulse `hough_done` together with a final `rd_en`. Required: that read still returns with `rd_valid`, `frame_count`=1, and CLEAR re-runs 12 cycles before `wr_ready`.
- **Violations.** Drive `wr_en` during CLEAR and `rd_en` during FILL. Required: no BRAM write and no `rd_valid`; `wr_overrun`=1 and `rd_overrun`=1, held until reset.
- **Mid-frame reset.** Assert `reset` mid-READ. Required: all outputs 0 immediately, and a new CLEAR from address 0 after release.
